// File: rtl/id_stage.sv
// Decode stage: splits instructions, reads operands, builds the ALU bundle.
// Define ID_STAGE_SKID_EN to add a one-entry skid buffer (registered in_ready).
module id_stage #(
   parameter int WORD_SIZE  = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_SIZE-1:0]  in_inst,
   input  logic [WORD_SIZE-1:0]  in_pc,
   input  logic                  flush,
   output logic [REG_ADDR_W-1:0] rs1_addr,
   output logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [WORD_SIZE-1:0]  rs1_data,
   input  logic [WORD_SIZE-1:0]  rs2_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [6:0]            opcode,
   output logic [6:0]            funct7,
   output logic [2:0]            funct3,
   output logic [WORD_SIZE-1:0]  alu_in1,
   output logic [WORD_SIZE-1:0]  alu_in2,
   output logic [WORD_SIZE-1:0]  store_data,
   output logic [WORD_SIZE-1:0]  branch_target,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic                  rd_we,
   output logic [WORD_SIZE-1:0]  exception_code
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [WORD_SIZE-1:0] EXC_ILLEGAL = WORD_SIZE'(2);

   typedef struct packed {
      logic [6:0]            opcode;
      logic [6:0]            funct7;
      logic [2:0]            funct3;
      logic [WORD_SIZE-1:0]  in1;
      logic [WORD_SIZE-1:0]  in2;
      logic [WORD_SIZE-1:0]  sdata;
      logic [WORD_SIZE-1:0]  target;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic [WORD_SIZE-1:0]  exc;
   } bundle_t;

   logic [6:0]           f_op;
   logic [6:0]           f_f7;
   logic [2:0]           f_f3;
   logic [WORD_SIZE-1:0] imm_i;
   logic [WORD_SIZE-1:0] imm_s;
   logic [WORD_SIZE-1:0] imm_b;
   logic [WORD_SIZE-1:0] imm_j;
   logic                 r_ok;
   logic                 legal;
   logic                 xfer;
   bundle_t              dec;
   bundle_t              out_q;
   bundle_t              out_d;
   logic                 out_valid_q;
   logic                 out_valid_d;

   assign f_op = in_inst[6:0];
   assign f_f7 = in_inst[31:25];
   assign f_f3 = in_inst[14:12];

   assign rs1_addr = REG_ADDR_W'(in_inst[19:15]);
   assign rs2_addr = REG_ADDR_W'(in_inst[24:20]);

   assign imm_i = {{(WORD_SIZE-12){in_inst[31]}}, in_inst[31:20]};
   assign imm_s = {{(WORD_SIZE-12){in_inst[31]}},
                   in_inst[31:25], in_inst[11:7]};
   assign imm_b = {{(WORD_SIZE-13){in_inst[31]}}, in_inst[31],
                   in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_j = {{(WORD_SIZE-21){in_inst[31]}}, in_inst[31],
                   in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

   // Only ADD/SUB/OR/AND/MUL are supported R-type operations.
   assign r_ok = ((f_f7 == 7'b0000000) &&
                  (f_f3 == 3'b000 || f_f3 == 3'b110 || f_f3 == 3'b111))
              || ((f_f7 == 7'b0100000) && (f_f3 == 3'b000))
              || ((f_f7 == 7'b0000001) && (f_f3 == 3'b000));

   always_comb begin
      dec        = '0;
      legal      = 1'b1;
      dec.opcode = f_op;
      dec.funct7 = f_f7;
      dec.funct3 = f_f3;
      unique case (1'b1)
         (f_op == OP_R): begin
            legal   = r_ok;
            dec.in1 = rs1_data;
            dec.in2 = rs2_data;
            dec.we  = 1'b1;
         end
         (f_op == OP_IMM): begin
            legal   = (f_f3 == 3'b000);
            dec.in1 = rs1_data;
            dec.in2 = imm_i;
            dec.we  = 1'b1;
         end
         (f_op == OP_LD): begin
            dec.in1 = rs1_data;
            dec.in2 = imm_i;
            dec.we  = 1'b1;
         end
         (f_op == OP_ST): begin
            dec.in1   = rs1_data;
            dec.in2   = imm_s;
            dec.sdata = rs2_data;
         end
         (f_op == OP_BR): begin
            dec.in1    = rs1_data;
            dec.in2    = rs2_data;
            dec.target = in_pc + imm_b;
         end
         (f_op == OP_JAL): begin
            dec.in1    = in_pc + WORD_SIZE'(4);
            dec.target = in_pc + imm_j;
            dec.we     = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      // Illegal bundles still travel down the pipe, just inert.
      if (!legal) begin
         dec.in1    = '0;
         dec.in2    = '0;
         dec.sdata  = '0;
         dec.target = '0;
         dec.we     = 1'b0;
         dec.exc    = EXC_ILLEGAL;
      end
      dec.rd = dec.we ? REG_ADDR_W'(in_inst[11:7]) : '0;
   end

`ifdef ID_STAGE_SKID_EN
   bundle_t skid_q;
   bundle_t skid_d;
   logic    skid_full_q;
   logic    skid_full_d;

   assign in_ready = !skid_full_q;
   assign xfer     = in_valid && in_ready;

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      skid_d      = skid_q;
      skid_full_d = skid_full_q;
      if (flush) begin
         out_valid_d = 1'b0;
         skid_full_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         if (skid_full_q) begin
            out_d       = skid_q;
            out_valid_d = 1'b1;
            skid_full_d = 1'b0;
         end else if (xfer) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (xfer) begin
         skid_d      = dec;
         skid_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q      <= '0;
         skid_full_q <= 1'b0;
      end else begin
         skid_q      <= skid_d;
         skid_full_q <= skid_full_d;
      end
   end
`else
   assign in_ready = !out_valid_q || out_ready;
   assign xfer     = in_valid && in_ready;

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (xfer) begin
         out_d       = dec;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign opcode         = out_q.opcode;
   assign funct7         = out_q.funct7;
   assign funct3         = out_q.funct3;
   assign alu_in1        = out_q.in1;
   assign alu_in2        = out_q.in2;
   assign store_data     = out_q.sdata;
   assign branch_target  = out_q.target;
   assign rd_addr        = out_q.rd;
   assign rd_we          = out_q.we;
   assign exception_code = out_q.exc;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: decode model, handshake, stall, flush.
// Compile with ID_STAGE_SKID_EN defined to exercise the skid variant.
module tb_id_stage;

   localparam int W  = 32;
   localparam int RA = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_inst;
   logic [W-1:0]  in_pc;
   logic          flush;
   logic [RA-1:0] rs1_addr;
   logic [RA-1:0] rs2_addr;
   logic [W-1:0]  rs1_data;
   logic [W-1:0]  rs2_data;
   logic          out_valid;
   logic          out_ready;
   logic [6:0]    opcode;
   logic [6:0]    funct7;
   logic [2:0]    funct3;
   logic [W-1:0]  alu_in1;
   logic [W-1:0]  alu_in2;
   logic [W-1:0]  store_data;
   logic [W-1:0]  branch_target;
   logic [RA-1:0] rd_addr;
   logic          rd_we;
   logic [W-1:0]  exception_code;

   typedef struct packed {
      logic [6:0]    op;
      logic [6:0]    f7;
      logic [2:0]    f3;
      logic [W-1:0]  in1;
      logic [W-1:0]  in2;
      logic [W-1:0]  sd;
      logic [W-1:0]  bt;
      logic [RA-1:0] rd;
      logic          we;
      logic [W-1:0]  exc;
   } bund_t;

   bund_t        sb[$];
   bund_t        cur;
   logic [W-1:0] rf[32];
   int           checks = 0;
   int           passed = 0;

   always #5 clk = ~clk;

   assign rs1_data = rf[rs1_addr];
   assign rs2_data = rf[rs2_addr];
   assign cur = {opcode, funct7, funct3, alu_in1, alu_in2, store_data,
                 branch_target, rd_addr, rd_we, exception_code};

   id_stage #(.WORD_SIZE(W), .REG_ADDR_W(RA)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .funct7(funct7), .funct3(funct3),
      .alu_in1(alu_in1), .alu_in2(alu_in2),
      .store_data(store_data), .branch_target(branch_target),
      .rd_addr(rd_addr), .rd_we(rd_we),
      .exception_code(exception_code)
   );

   function automatic bund_t model(input logic [W-1:0] i,
                                   input logic [W-1:0] pc,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
      bund_t        e;
      logic         ok;
      logic [W-1:0] ii, is, ib, ij;
      ii = {{20{i[31]}}, i[31:20]};
      is = {{20{i[31]}}, i[31:25], i[11:7]};
      ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      e = '0;
      e.op = i[6:0];
      e.f7 = i[31:25];
      e.f3 = i[14:12];
      ok = 1'b1;
      case (i[6:0])
         7'h33: begin
            ok = (e.f7 == 7'h00 && e.f3 inside {3'd0, 3'd6, 3'd7})
              || (e.f7 == 7'h20 && e.f3 == 3'd0)
              || (e.f7 == 7'h01 && e.f3 == 3'd0);
            e.in1 = a; e.in2 = b; e.we = 1'b1;
         end
         7'h13: begin
            ok = (e.f3 == 3'd0);
            e.in1 = a; e.in2 = ii; e.we = 1'b1;
         end
         7'h03: begin e.in1 = a; e.in2 = ii; e.we = 1'b1; end
         7'h23: begin e.in1 = a; e.in2 = is; e.sd = b; end
         7'h63: begin e.in1 = a; e.in2 = b; e.bt = pc + ib; end
         7'h6F: begin e.in1 = pc + 4; e.bt = pc + ij; e.we = 1'b1; end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.in1 = '0; e.in2 = '0; e.sd = '0; e.bt = '0;
         e.we = 1'b0; e.exc = 2;
      end
      e.rd = e.we ? i[11:7] : '0;
      return e;
   endfunction

   // One clock: note handshakes at the negedge, then advance to posedge+1.
   task automatic tick(output bit acc, output bit took, output bund_t act);
      @(negedge clk);
      acc  = in_valid && in_ready && !flush;
      took = out_valid && out_ready && !flush;
      act  = cur;
      if (acc) sb.push_back(model(in_inst, in_pc, rs1_data, rs2_data));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit acc, took;
      bund_t act;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0",
                  in_ready, out_valid);
      else passed++;
      in_inst = 32'h002081B3; in_pc = 32'h40;
      in_valid = 1'b1; out_ready = 1'b0;
      tick(acc, took, act);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1)
         $display("FAIL reset_preload: out_valid=%b want 1", out_valid);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || cur !== '0)
         $display("FAIL reset_async: out_valid=%b bundle=%h want 0/0",
                  out_valid, cur);
      else passed++;
      sb.delete();
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL reset_after: in_ready=%b out_valid=%b want 1/0",
                  in_ready, out_valid);
      else passed++;
   endtask

   task automatic test_add();
      bit acc, took;
      bund_t act, e, k;
      k = '0;
      k.op = 7'h33; k.in1 = 5; k.in2 = 7; k.rd = 3; k.we = 1'b1;
      in_inst = 32'h002081B3; in_pc = 32'h0;
      in_valid = 1'b1; out_ready = 1'b1;
      tick(acc, took, act);
      in_valid = 1'b0;
      tick(acc, took, act);
      checks++;
      if (!took) $display("FAIL add_latency: no output one cycle later");
      else begin
         e = sb.pop_front();
         if (act !== k)
            $display("FAIL add_fields: got %h want %h", act, k);
         else if (act !== e)
            $display("FAIL add_model: got %h want %h", act, e);
         else passed++;
      end
   endtask

   task automatic test_imm();
      logic [W-1:0] ins[3] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3};
      bund_t cap[3];
      bit acc, took;
      bund_t act, e;
      int k = 0, n = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && k < 3; c++) begin
         if (n < 3) begin
            in_valid = 1'b1; in_inst = ins[n]; in_pc = 32'h100;
         end else in_valid = 1'b0;
         tick(acc, took, act);
         if (acc) n++;
         if (took) begin
            e = sb.pop_front();
            cap[k] = act; k++;
            checks++;
            if (act !== e) $display("FAIL imm_model: got %h want %h", act, e);
            else passed++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (k != 3) $display("FAIL imm_count: got %0d want 3", k);
      else begin
         passed++;
         checks++;
         if (cap[0].in2 !== 32'hFFFFFFFF)
            $display("FAIL addi_imm: got %h want ffffffff", cap[0].in2);
         else passed++;
         checks++;
         if ({cap[1].in2, cap[1].sd, cap[1].we} !== {32'd8, 32'd7, 1'b0})
            $display("FAIL sw_fields: in2=%h sd=%h we=%b want 8/7/0",
                     cap[1].in2, cap[1].sd, cap[1].we);
         else passed++;
         checks++;
         if (cap[2].bt !== 32'h000000FC)
            $display("FAIL beq_target: got %h want 000000fc", cap[2].bt);
         else passed++;
      end
   endtask

   task automatic test_stall();
      bit acc, took;
      bund_t act, e;
      int pops = 0;
      in_inst = 32'h00108293; in_pc = 32'h200;
      in_valid = 1'b1; out_ready = 1'b0;
      tick(acc, took, act);
      checks++;
      if (!acc) $display("FAIL stall_first: first instruction not taken");
      else passed++;
      in_inst = 32'h0020E1B3; in_pc = 32'h204;
      for (int c = 0; c < 3; c++) begin
         tick(acc, took, act);
         if (acc) in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || sb.size() == 0 || act !== sb[0])
            $display("FAIL stall_hold: out_valid=%b bundle=%h", out_valid, act);
         else passed++;
`ifndef ID_STAGE_SKID_EN
         checks++;
         if (acc) $display("FAIL stall_ready: in_ready=1 want 0");
         else passed++;
`endif
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10 && (in_valid || sb.size() != 0); c++) begin
         tick(acc, took, act);
         if (acc) in_valid = 1'b0;
         if (took) begin
            e = sb.pop_front();
            pops++;
            checks++;
            if (act !== e) $display("FAIL stall_order: got %h want %h", act, e);
            else passed++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (pops != 2) $display("FAIL stall_count: got %0d want 2", pops);
      else passed++;
   endtask

   task automatic test_illegal();
      logic [W-1:0] ins[3] = '{32'h00000073, 32'h4020F1B3, 32'h00109093};
      bit acc, took;
      bund_t act, e;
      int n = 0, k = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && k < 3; c++) begin
         if (n < 3) begin
            in_valid = 1'b1; in_inst = ins[n]; in_pc = 32'h300;
         end else in_valid = 1'b0;
         tick(acc, took, act);
         if (acc) n++;
         if (took) begin
            e = sb.pop_front();
            k++;
            checks++;
            if ({act.exc, act.we, act.rd, act.in1, act.in2} !==
                {32'd2, 1'b0, 5'd0, 64'd0})
               $display("FAIL illegal_fields: got %h", act);
            else if (act !== e)
               $display("FAIL illegal_model: got %h want %h", act, e);
            else passed++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (k != 3) $display("FAIL illegal_count: got %0d want 3", k);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ins[6] = '{32'h010000EF, 32'h022081B3, 32'h40208133,
                               32'h0040A203, 32'hFE000EE3, 32'h0020F1B3};
      logic [W-1:0] pcs[6] = '{32'hFFFFFFFC, 32'h10, 32'h14,
                               32'h18, 32'h0, 32'h20};
      bit acc, took;
      bund_t act, e;
      int k = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         in_valid = (c < 6);
         if (c < 6) begin in_inst = ins[c]; in_pc = pcs[c]; end
         tick(acc, took, act);
         if (c < 6) begin
            checks++;
            if (!acc) $display("FAIL b2b_accept: cycle %0d stalled", c);
            else passed++;
         end
         if (took) begin
            e = sb.pop_front();
            if (k == 0) begin
               checks++;
               if ({act.in1, act.bt} !== {32'h0, 32'hC})
                  $display("FAIL jal_wrap: link=%h tgt=%h want 0/c",
                           act.in1, act.bt);
               else passed++;
            end
            k++;
            checks++;
            if (act !== e) $display("FAIL b2b_model: got %h want %h", act, e);
            else passed++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (k != 6 || sb.size() != 0)
         $display("FAIL b2b_count: got %0d want 6", k);
      else passed++;
   endtask

   task automatic test_flush();
      bit acc, took;
      bund_t act;
      int seen = 0;
      in_inst = 32'h002081B3; in_pc = 32'h400;
      in_valid = 1'b1; out_ready = 1'b0;
      tick(acc, took, act);
      in_inst = 32'h00500313; flush = 1'b1;
      tick(acc, took, act);
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL flush_clear: out_valid=%b in_ready=%b want 0/1",
                  out_valid, in_ready);
      else passed++;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(acc, took, act);
         if (took) seen++;
      end
      checks++;
      if (seen != 0) $display("FAIL flush_leak: got %0d outputs want 0", seen);
      else passed++;
   endtask

   task automatic test_random();
      logic [W-1:0] tbl[8] = '{32'h002081B3, 32'h40000033, 32'h02000033,
                               32'h00000013, 32'h00002003, 32'h00002023,
                               32'h00001063, 32'h0000506F};
      bit acc = 1'b1, took;
      bund_t act, e;
      logic [W-1:0] t;
      for (int c = 0; c < 80; c++) begin
         if (!in_valid || acc) begin
            t = tbl[$urandom_range(0, 7)];
            t[11:7] = 5'($urandom);
            t[19:15] = 5'($urandom);
            t[24:20] = 5'($urandom);
            t[31] = 1'($urandom);
            in_inst = t;
            in_pc = $urandom;
            in_valid = ($urandom_range(0, 3) != 0) && (c < 70);
         end
         out_ready = ($urandom_range(0, 3) != 0) || (c >= 70);
         tick(acc, took, act);
         if (took) begin
            e = sb.pop_front();
            checks++;
            if (act !== e) $display("FAIL rand_model: got %h want %h", act, e);
            else passed++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (sb.size() != 0) $display("FAIL rand_drain: %0d left want 0", sb.size());
      else passed++;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'hA5000000 + i * 32'h111;
      rf[0] = '0; rf[1] = 32'd5; rf[2] = 32'd7;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_pc = '0;
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_add();
      test_imm();
      test_stall();
      test_illegal();
      test_back_to_back();
      test_flush();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
